calc_plus_serial: RTL and testbench

Multi-cycle two-operand adder for the K-means datapath. It is the additive counterpart of Calculation_minus and rebuilds coordinates and accumulates centroid sums from operands and differences. It computes sum = inputX + inputY + cin one DIGIT-wide slice per clock, with a start/done handshake. It exposes the per-bit carry vector in the same form as the subtract unit, so downstream logic can use either block.

---
 rtl/calc_pkg.sv | 18 +
 rtl/plus_digit.sv | 27 ++
 rtl/calc_plus_serial.sv | 143 ++++++++++++++
 tb/tb_calc_plus_serial.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the K-means add/subtract datapath units.
// Holds the default operand width, the FSM state encoding and a flag helper.
package calc_pkg;

  localparam int CALC_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } calc_state_e;

  // Signed overflow: carry into the sign bit differs from carry out of it.
  function automatic logic signed_ovf(input logic c_msb, input logic c_prev);
    return c_msb ^ c_prev;
  endfunction

endpackage

// File: rtl/plus_digit.sv
// Combinational DIGIT-bit ripple-carry slice.
// Produces the sum bits and the carry out of every bit position.
module plus_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic [DIGIT-1:0] c
);

  logic cc;

  // Ripple the carry through the slice, recording each bit's carry out.
  always_comb begin
    cc = ci;
    s  = '0;
    c  = '0;
    for (int i = 0; i < DIGIT; i++) begin
      s[i] = a[i] ^ b[i] ^ cc;
      c[i] = (a[i] & b[i]) | (cc & (a[i] ^ b[i]));
      cc   = c[i];
    end
  end

endmodule

// File: rtl/calc_plus_serial.sv
// Digit-serial adder: sum = inputX + inputY + cin, DIGIT bits per clock,
// with start/done handshake and the per-bit carry vector exposed as cout.
module calc_plus_serial
  import calc_pkg::*;
#(
  parameter int WIDTH = CALC_WIDTH,
  parameter int DIGIT = 1
) (
  input  logic             plus_clk,
  input  logic             plus_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] inputX,
  input  logic [WIDTH-1:0] inputY,
  input  logic             cin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic [WIDTH-1:0] cout,
  output logic             carry_out,
  output logic             overflow
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  calc_state_e      state_q, state_d;
  logic [WIDTH-1:0] x_q, x_d, y_q, y_d;
  logic [WIDTH-1:0] sum_sh_q, sum_sh_d, cy_sh_q, cy_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d, cout_q, cout_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             ready_q, ready_d, done_q, done_d;
  logic             carry_out_q, carry_out_d, overflow_q, overflow_d;

  logic [DIGIT-1:0] slice_s, slice_c;

  plus_digit #(.DIGIT(DIGIT)) u_digit (
    .a  (x_q[DIGIT-1:0]),
    .b  (y_q[DIGIT-1:0]),
    .ci (carry_q),
    .s  (slice_s),
    .c  (slice_c)
  );

  // Next-state and datapath update; result registers load only on the last digit.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    sum_sh_d    = sum_sh_q;
    cy_sh_d     = cy_sh_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    sum_d       = sum_q;
    cout_d      = cout_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x_d      = inputX;
          y_d      = inputY;
          carry_d  = cin;
          cnt_d    = '0;
          sum_sh_d = '0;
          cy_sh_d  = '0;
          state_d  = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // New digits enter at the top so the LSB digit ends at bit 0 after N shifts.
        x_d      = x_q >> DIGIT;
        y_d      = y_q >> DIGIT;
        sum_sh_d = {slice_s, sum_sh_q[WIDTH-1:DIGIT]};
        cy_sh_d  = {slice_c, cy_sh_q[WIDTH-1:DIGIT]};
        carry_d  = slice_c[DIGIT-1];
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          sum_d       = sum_sh_d;
          cout_d      = cy_sh_d;
          carry_out_d = cy_sh_d[WIDTH-1];
          overflow_d  = signed_ovf(cy_sh_d[WIDTH-1], cy_sh_d[WIDTH-2]);
          done_d      = 1'b1;
          state_d     = DONE;
        end else begin
          state_d = RUN;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    ready_d = (state_d == IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge plus_clk) begin
    if (plus_rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      sum_sh_q    <= '0;
      cy_sh_q     <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      sum_q       <= '0;
      cout_q      <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      ready_q     <= 1'b1;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sum_sh_q    <= sum_sh_d;
      cy_sh_q     <= cy_sh_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  assign ready     = ready_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_calc_plus_serial.sv
// Directed self-checking bench for calc_plus_serial with DIGIT=1 and DIGIT=4 instances.
module tb_calc_plus_serial;

  logic        clk = 1'b0;
  logic        rst1, rst4, start1, start4, cin;
  logic [31:0] x, y;
  logic        ready1, done1, co1, ovf1;
  logic [31:0] sum1, cout1;
  logic        ready4, done4, co4, ovf4;
  logic [31:0] sum4, cout4;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;
  int edges;
  int dones;
  bit early_ready;

  always #5 clk = ~clk;

  calc_plus_serial #(.WIDTH(32), .DIGIT(1)) dut1 (
    .plus_clk(clk), .plus_rst(rst1), .start(start1), .inputX(x), .inputY(y), .cin(cin),
    .ready(ready1), .done(done1), .sum(sum1), .cout(cout1), .carry_out(co1), .overflow(ovf1)
  );

  calc_plus_serial #(.WIDTH(32), .DIGIT(4)) dut4 (
    .plus_clk(clk), .plus_rst(rst4), .start(start4), .inputX(x), .inputY(y), .cin(cin),
    .ready(ready4), .done(done4), .sum(sum4), .cout(cout4), .carry_out(co4), .overflow(ovf4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start1 for one edge with the given operands (this edge is E0).
  task automatic launch1(input logic [31:0] xa, input logic [31:0] ya, input logic ca);
    x = xa; y = ya; cin = ca; start1 = 1'b1;
    tick();
    start1 = 1'b0;
  endtask

  // Count edges after E0 until done1 is seen; -1 on timeout.
  task automatic wait_done1(output int n);
    n = -1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (done1) begin
        n = k;
        break;
      end
    end
  endtask

  initial begin
    rst1 = 1'b1; rst4 = 1'b1; start1 = 1'b0; start4 = 1'b0;
    cin = 1'b0; x = 32'd0; y = 32'd0;
    tick(); tick();
    rst1 = 1'b0; rst4 = 1'b0;
    chk("reset_ready", {31'd0, ready1}, 32'd1);
    chk("reset_done", {31'd0, done1}, 32'd0);
    chk("reset_sum", sum1, 32'd0);
    chk("reset_cout", cout1, 32'd0);
    chk("reset_flags", {30'd0, co1, ovf1}, 32'd0);

    // 50 + 13
    launch1(32'd50, 32'd13, 1'b0);
    chk("run_ready_low", {31'd0, ready1}, 32'd0);
    wait_done1(edges);
    chk("basic_latency", edges, 32'd32);
    chk("basic_sum", sum1, 32'd63);
    chk("basic_cout", cout1, 32'd0);
    chk("basic_flags", {30'd0, co1, ovf1}, 32'd0);
    tick();
    chk("done_one_cycle", {31'd0, done1}, 32'd0);
    chk("ready_after_done", {31'd0, ready1}, 32'd1);

    // 103 + 86 + 1 with X changed mid-run
    launch1(32'd103, 32'd86, 1'b1);
    tick(); tick(); tick();
    x = 32'd834;
    wait_done1(edges);
    chk("midrun_latency", edges, 32'd29);
    chk("midrun_sum", sum1, 32'd190);
    tick();

    // 0xFFFFFFFF + 1 wraps
    launch1(32'hFFFF_FFFF, 32'd1, 1'b0);
    wait_done1(edges);
    chk("wrap_sum", sum1, 32'd0);
    chk("wrap_cout", cout1, 32'hFFFF_FFFF);
    chk("wrap_carry_out", {31'd0, co1}, 32'd1);
    chk("wrap_overflow", {31'd0, ovf1}, 32'd0);
    tick();

    // 0x7FFFFFFF + 1 signed overflow
    launch1(32'h7FFF_FFFF, 32'd1, 1'b0);
    wait_done1(edges);
    chk("ovf_sum", sum1, 32'h8000_0000);
    chk("ovf_cout", cout1, 32'h7FFF_FFFF);
    chk("ovf_carry_out", {31'd0, co1}, 32'd0);
    chk("ovf_overflow", {31'd0, ovf1}, 32'd1);
    tick();

    // Second start during RUN is ignored
    launch1(32'd536, 32'd464, 1'b0);
    dones = 0;
    early_ready = 1'b0;
    edges = -1;
    for (int k = 1; k <= 45; k++) begin
      start1 = (k == 5);
      if (k == 5) begin
        x = 32'd1; y = 32'd1;
      end
      tick();
      if (done1) begin
        dones++;
        if (edges < 0) edges = k;
      end
      if (ready1 && edges < 0) early_ready = 1'b1;
    end
    start1 = 1'b0;
    chk("restart_done_count", dones, 32'd1);
    chk("restart_latency", edges, 32'd32);
    chk("restart_sum", sum1, 32'd1000);
    chk("restart_no_early_ready", {31'd0, early_ready}, 32'd0);

    // Reset after 10 RUN edges aborts the operation
    launch1(32'd11, 32'd22, 1'b0);
    for (int k = 0; k < 10; k++) tick();
    rst1 = 1'b1;
    tick();
    rst1 = 1'b0;
    chk("abort_sum", sum1, 32'd0);
    chk("abort_ready", {31'd0, ready1}, 32'd1);
    chk("abort_done", {31'd0, done1}, 32'd0);
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (done1) dones++;
    end
    chk("abort_no_done", dones, 32'd0);
    chk("abort_sum_held", sum1, 32'd0);

    // DIGIT=4 instance: 416 + 87 in 8 edges
    x = 32'd416; y = 32'd87; cin = 1'b0; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    edges = -1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      if (done4) begin
        edges = k;
        break;
      end
    end
    chk("d4_latency", edges, 32'd8);
    chk("d4_sum", sum4, 32'd503);
    chk("d4_flags", {30'd0, co4, ovf4}, 32'd0);
    tick();
    chk("d4_ready_after", {31'd0, ready4}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
